// File: rtl/uart_rx_frame.sv
// UART receiver: synchronized RX line, mid-bit sampling with false-start rejection,
// configurable word/parity/stop format, error flags and a one-word valid/ready buffer.
module uart_rx_frame #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // Preload so the first tick lands CLKS_PER_BIT/2 cycles after the start edge.
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 sync1_q, sync2_q, prev_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rxs;
  logic tick;
  logic exp_par;
  logic deliver;

  assign rxs     = sync2_q;
  assign tick    = (baud_q == BAUD_LAST);
  assign exp_par = (^shift_q) ^ (PARITY_MODE == 2);

  always_comb begin
    state_d     = state_q;
    baud_d      = tick ? '0 : baud_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    deliver     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = baud_q;
        if (prev_q && !rxs) begin
          state_d     = S_START;
          baud_d      = BAUD_HALF;
          bit_d       = '0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[WORD_SIZE-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (rxs != exp_par) perr_pend_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rxs) ferr_pend_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            deliver = 1'b1;
            state_d = (ferr_pend_q || !rxs) ? S_BREAK : S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer: a consume and a deliver on the same edge keeps rx_valid high.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_pend_q;
        ferr_d  = ferr_pend_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync1_q     <= rx_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: two configurations (8E1 and 5O2) driven with directed and
// random frames; received words are compared against a frame-level reference model.
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(rst), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a),
    .busy(busy_a)
  );

  uart_rx_frame #(.WORD_SIZE(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(rst), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b),
    .busy(busy_b)
  );

  // Items are {parity_err, frame_err, 9-bit data}, recorded on every accepted handshake.
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  int ovr_cnt_a = 0;
  int busy_cnt_a = 0;
  int rd_a = 0;
  int rd_b = 0;

  always @(negedge clk) begin
    if (valid_a && ready_a) qa.push_back({perr_a, ferr_a, 1'b0, data_a});
    if (valid_b && ready_b) qb.push_back({perr_b, ferr_b, 4'b0, data_b});
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int w_of(input int which);
    return (which == 0) ? 8 : 5;
  endfunction

  function automatic int pm_of(input int which);
    return (which == 0) ? 1 : 2;
  endfunction

  function automatic int st_of(input int which);
    return (which == 0) ? 1 : 2;
  endfunction

  // Line bits LSB-first: start, data, optional parity (flipped on request), stop bits.
  function automatic logic [15:0] build(input int which, input logic [8:0] word,
                                        input bit flip, input logic [1:0] stopv,
                                        output int n);
    logic [15:0] fr;
    int w, idx, ones;
    bit par;
    fr = '1;
    w = w_of(which);
    fr[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < w; i++) begin
      fr[1 + i] = word[i];
      ones += int'(word[i]);
    end
    idx = 1 + w;
    par = ((ones % 2) == 1) ^ (pm_of(which) == 2);
    fr[idx] = par ^ flip;
    idx++;
    for (int s = 0; s < st_of(which); s++) begin
      fr[idx] = stopv[s];
      idx++;
    end
    n = idx;
    return fr;
  endfunction

  function automatic logic [10:0] model(input int which, input logic [8:0] word,
                                        input bit flip, input logic [1:0] stopv);
    logic [8:0] mask;
    bit fe;
    mask = 9'((1 << w_of(which)) - 1);
    fe = 1'b0;
    for (int s = 0; s < st_of(which); s++) if (!stopv[s]) fe = 1'b1;
    return {flip, fe, word & mask};
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  function automatic int pending(input int which);
    return (which == 0) ? (qa.size() - rd_a) : (qb.size() - rd_b);
  endfunction

  task automatic take(input int which, output logic [10:0] item);
    item = 'x;
    if (which == 0) begin
      if (qa.size() > rd_a) item = qa[rd_a];
      rd_a++;
    end else begin
      if (qb.size() > rd_b) item = qb[rd_b];
      rd_b++;
    end
  endtask

  task automatic send_bits(input int which, input logic [15:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(which, fr[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  // Send one frame with the consumer ready, check exactly one word arrived, then idle.
  task automatic xfer(input int which, input logic [8:0] word, input bit flip,
                      input logic [1:0] stopv, input int gap, input string tag);
    logic [15:0] fr;
    logic [10:0] item;
    int n;
    fr = build(which, word, flip, stopv, n);
    send_bits(which, fr, n);
    check({tag, "_count"}, pending(which), 1);
    take(which, item);
    check({tag, "_item"}, item, model(which, word, flip, stopv));
    set_rx(which, 1'b1);
    repeat (gap * CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] fr;
    logic [10:0] item;
    int n, b0, o0, which, gap;
    logic [8:0] word;
    bit flip;
    logic [1:0] stopv;

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_flags_a", {perr_a, ferr_a, ovr_a}, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_data_b", data_b, 0);
    check("rst_flags_b", {perr_b, ferr_b, ovr_b, busy_b}, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Clean word, consumer always ready: one-cycle valid.
    xfer(0, 9'h0A5, 1'b0, 2'b11, 1, "a5");
    check("a5_valid_low", valid_a, 0);
    check("a5_hold", data_a, 8'hA5);

    // Even parity on 0x07 needs a 1; send a 0 first, then the correct bit.
    xfer(0, 9'h007, 1'b1, 2'b11, 1, "par_bad");
    check("par_bad_flag", perr_a, 1);
    xfer(0, 9'h007, 1'b0, 2'b11, 1, "par_ok");
    check("par_ok_flag", perr_a, 0);

    // Four-cycle low glitch: busy for half a bit, no word.
    b0 = busy_cnt_a;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_busy_cycles", busy_cnt_a - b0, CPB / 2);
    check("glitch_no_word", pending(0), 0);
    check("glitch_busy_end", busy_a, 0);

    // Consumer stalled: second back-to-back frame is dropped with one overrun pulse.
    ready_a = 1'b0;
    o0 = ovr_cnt_a;
    fr = build(0, 9'h011, 1'b0, 2'b11, n);
    send_bits(0, fr, n);
    fr = build(0, 9'h022, 1'b0, 2'b11, n);
    send_bits(0, fr, n);
    check("ovr_valid", valid_a, 1);
    check("ovr_data", data_a, 8'h11);
    check("ovr_pulses", ovr_cnt_a - o0, 1);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_consumed", valid_a, 0);
    check("ovr_count", pending(0), 1);
    take(0, item);
    check("ovr_item", item, model(0, 9'h011, 1'b0, 2'b11));
    check("ovr_hold", data_a, 8'h11);
    repeat (CPB) @(posedge clk);
    #1;

    // Line held low for 30 bit times: one framing-error word of zeros, then nothing.
    rx_a = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    check("brk_count", pending(0), 1);
    take(0, item);
    check("brk_item", item, {1'b0, 1'b1, 9'h000});
    check("brk_busy", busy_a, 1);
    rx_a = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("brk_no_more", pending(0), 0);
    check("brk_idle", busy_a, 0);

    // 5O2: hold a word, then reset in the middle of the next frame's data bits.
    ready_b = 1'b0;
    fr = build(1, 9'h00A, 1'b0, 2'b11, n);
    send_bits(1, fr, n);
    check("b_hold_valid", valid_b, 1);
    check("b_hold_data", data_b, 5'h0A);
    fr = build(1, 9'h01F, 1'b0, 2'b11, n);
    send_bits(1, fr, 3);
    check("b_mid_busy", busy_b, 1);
    rst = 1'b1;
    #1;
    check("b_rst_valid", valid_b, 0);
    check("b_rst_data", data_b, 0);
    check("b_rst_flags", {perr_b, ferr_b, ovr_b, busy_b}, 0);
    rx_b = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_b = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("b_after_rst_none", pending(1), 0);
    xfer(1, 9'h01B, 1'b0, 2'b11, 0, "b_1b");

    // Random frames on both configurations with occasional parity/stop corruption.
    for (int i = 0; i < 24; i++) begin
      which = i % 2;
      word  = 9'($urandom);
      flip  = ($urandom % 4) == 0;
      stopv = 2'b11;
      if (($urandom % 4) == 0) stopv[$urandom % st_of(which)] = 1'b0;
      gap = (stopv == 2'b11) ? int'($urandom % 2) : 1 + int'($urandom % 2);
      xfer(which, word, flip, stopv, gap, (which == 0) ? "rnd_a" : "rnd_b");
    end
    check("final_no_extra_a", pending(0), 0);
    check("final_no_extra_b", pending(1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver. It replaces the fixed 8-bit receive datapath and adds:

- an input synchronizer,
- mid-bit sampling with false-start rejection,
- configurable word size, parity and stop bits,
- error flags,
- a one-word output buffer with a valid/ready handshake.

It sits between the external RX pin and the command/packet parser.

## Interface

- WORD_SIZE, 8, data bits per frame, legal range 5..9
- CLKS_PER_BIT, 868, clk cycles per bit period, minimum 8 (868 = 115200 baud at 100 MHz)
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rx_in  input  1  raw serial line, idle high, asynchronous to clk
- rx_data  output  WORD_SIZE  received word, LSB = first bit on the line
- rx_valid  output  1  rx_data and the error flags are valid
- rx_ready  input  1  consumer accepts the word
- parity_err  output  1  parity mismatch for the word in rx_data (always 0 when PARITY_MODE = 0)
- frame_err  output  1  a stop bit was sampled low for the word in rx_data
- overrun_err  output  1  one-cycle pulse: a completed frame was dropped
- busy  output  1  high from start-bit detection until return to IDLE

## Operation

- rx_in passes through a 2-flop synchronizer, both flops reset to 1. All logic below uses the synchronized line (rxs).
- A baud counter runs 0..CLKS_PER_BIT-1. A bit counter runs 0..WORD_SIZE-1. The shift register shifts right, new bit enters at the MSB, so the word is LSB-first.
- State machine:
  - IDLE: a falling edge on rxs loads the baud counter to target CLKS_PER_BIT/2 (integer division) and goes to START.
  - START: at the half-bit point, if rxs = 1 it is a false start: go to IDLE, no output. If rxs = 0, go to DATA.
  - DATA: sample rxs every CLKS_PER_BIT cycles, WORD_SIZE times. Then go to PARITY if PARITY_MODE ≠ 0, otherwise to STOP.
  - PARITY: one sample. Expected value is the XOR of the data bits for even, the inverted XOR for odd. A mismatch sets the pending parity flag.
  - STOP: STOP_BITS samples, one bit period apart. Any low sample sets the pending frame flag. After the last sample, deliver (see below). If a frame error occurred, go to BREAK, otherwise to IDLE.
  - BREAK: wait until rxs = 1, then go to IDLE. A held-low line therefore produces exactly one frame.
- Deliver:
  - If rx_valid = 0, or rx_ready = 1 in the same cycle, load rx_data, parity_err and frame_err and set rx_valid.
  - Otherwise keep the old word and flags, drop the new frame and pulse overrun_err for 1 cycle.
- Handshake: when rx_valid and rx_ready are both high at a clock edge, the word is consumed. rx_valid clears on that edge unless a deliver occurs on the same edge, in which case rx_valid stays high with the new word.
- rx_data and the flags are stable while rx_valid = 1 and are held after consumption.

## Timing

- Reset values:
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0
  - state = IDLE, synchronizer = 1
- The synchronizer adds 2 cycles of latency.
- Let edge detection occur at cycle T. Sample k (k = 0 is the start-bit check) occurs at T + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
- rx_valid rises 1 cycle after the final stop-bit sample. overrun_err pulses on that same cycle when a frame is dropped.
- busy rises the cycle after edge detection. It falls when the state machine enters IDLE.
- The state machine can detect a new start edge on the cycle after returning to IDLE. Back-to-back frames with zero idle time are received without loss.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The partial frame is discarded and no flag is set.

## Test plan

- WORD_SIZE = 8, PARITY_MODE = 0, CLKS_PER_BIT = 16; send 0xA5 with rx_ready = 1 -> rx_valid for exactly 1 cycle, rx_data = 0xA5, all flags 0.
- PARITY_MODE = 1; send 0x07 with the parity bit = 0 (correct value is 1) -> rx_data = 0x07, parity_err = 1. Resend with parity bit = 1 -> parity_err = 0.
- Low glitch of 4 cycles on an idle line (CLKS_PER_BIT = 16) -> no rx_valid; busy pulses then returns to 0.
- rx_ready = 0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun_err pulses once at the end of 0x22. Raise rx_ready -> rx_valid drops.
- Hold rx_in low for 30 bit periods -> exactly one frame with rx_data = 0x00 and frame_err = 1. No further frames until rx_in returns high.
- STOP_BITS = 2, WORD_SIZE = 5; assert reset midway through the data bits -> outputs at reset values. A following frame 0x1B is received correctly.
